// File: rtl/switch_accumulator_pkg.sv
// Purpose: shared types and constants for the switch accumulator and its key debouncer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package switch_accumulator_pkg;

   // Debounced key state; RELEASED/PRESS_WAIT mean "released", PRESSED/RELEASE_WAIT mean "pressed".
   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } deb_state_e;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // Bits needed to hold values 0..value-1 (minimum 1 bit).
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Purpose: synchronise and debounce an active-low pushbutton, emit one strobe per press.
// Latency: press_evt high DEBOUNCE_CYCLES+2 cycles after the first low sample (registered).
// Backpressure: none; the key is free-running and every qualified press produces one strobe.
module key_debounce
   import switch_accumulator_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk_clk,
   input  logic reset_reset,
   input  logic key_n,
   output logic press_evt,
   output logic pressed
);

   localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]       sync_q;
   logic             key_s;
   deb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             evt_q, evt_d;
   logic             deb_n;

   assign key_s = sync_q[1];
   // Debounced level in the same active-low sense as key_s.
   assign deb_n = !((state_q == PRESSED) || (state_q == RELEASE_WAIT));

   // Two-flop synchroniser, reset to "released".
   always_ff @(posedge clk_clk) begin
      if (reset_reset) sync_q <= 2'b11;
      else             sync_q <= {sync_q[0], key_n};
   end

   // Next state: counter runs only while the synchronised key disagrees with the debounced level.
   always_comb begin
      state_d = state_q;
      evt_d   = 1'b0;
      cnt_d   = (key_s == deb_n) ? '0 : cnt_q + CNT_W'(1);
      case (state_q)
         RELEASED: begin
            if (!key_s) state_d = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
               state_d = PRESSED;
               cnt_d   = '0;
               evt_d   = 1'b1;
            end else if (key_s) begin
               state_d = RELEASED;
            end
         end
         PRESSED: begin
            if (key_s) state_d = RELEASE_WAIT;
         end
         RELEASE_WAIT: begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else if (!key_s) begin
               state_d = PRESSED;
            end
         end
         default: state_d = RELEASED;
      endcase
   end

   // State, counter and strobe registers.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q <= RELEASED;
         cnt_q   <= '0;
         evt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         evt_q   <= evt_d;
      end
   end

   assign press_evt = evt_q;
   assign pressed   = !deb_n;

endmodule

// File: rtl/switch_accumulator.sv
// Purpose: add the switch value into an accumulator on each debounced key press; optional one-level undo (ACC_UNDO_EN).
// Latency: LEDs and acc_pulse update one cycle after the debouncer's press strobe (DEBOUNCE_CYCLES+3 after first low sample).
// Backpressure: none; clear beats a press, a press beats undo, and a lost press is simply dropped.
module switch_accumulator
   import switch_accumulator_pkg::*;
#(
   parameter int DATA_W          = 8,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SAT_MODE        = MODE_WRAP
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic [DATA_W-1:0] switches_wire_export,
   input  logic              accumulate_wire_export,
   input  logic              clear_wire_export,
`ifdef ACC_UNDO_EN
   input  logic              undo_wire_export,
`endif
   output logic [DATA_W-1:0] led_wire_export,
   output logic              overflow_export,
   output logic              acc_pulse_export
);

   logic              press_evt, key_pressed, go;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic              ovf_q, ovf_d;
   logic              pulse_q, pulse_d;
`ifdef ACC_UNDO_EN
   logic [DATA_W-1:0] prev_acc_q, prev_acc_d;
   logic              prev_ovf_q, prev_ovf_d;
   logic              armed_q, armed_d;
   logic              undo_prev_q;
   logic              undo_rise;
   assign undo_rise = undo_wire_export && !undo_prev_q;
`endif

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_key_debounce (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .key_n       (accumulate_wire_export),
      .press_evt   (press_evt),
      .pressed     (key_pressed)
   );

   // The strobe always coincides with the debounced pressed level; qualifying keeps the two consistent.
   assign go  = press_evt && key_pressed;
   assign sum = {1'b0, acc_q} + {1'b0, switches_wire_export};

   // Accumulator next state: clear, then accumulate, then undo.
   always_comb begin
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      pulse_d = 1'b0;
`ifdef ACC_UNDO_EN
      prev_acc_d = prev_acc_q;
      prev_ovf_d = prev_ovf_q;
      armed_d    = armed_q;
`endif
      if (clear_wire_export) begin
         acc_d = '0;
         ovf_d = 1'b0;
`ifdef ACC_UNDO_EN
         armed_d = 1'b0;
`endif
      end else if (go) begin
         pulse_d = 1'b1;
`ifdef ACC_UNDO_EN
         prev_acc_d = acc_q;
         prev_ovf_d = ovf_q;
         armed_d    = 1'b1;
`endif
         if (sum[DATA_W]) begin
            ovf_d = 1'b1;
            acc_d = (SAT_MODE == MODE_SAT) ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
         end else begin
            acc_d = sum[DATA_W-1:0];
         end
      end
`ifdef ACC_UNDO_EN
      else if (undo_rise && armed_q) begin
         acc_d   = prev_acc_q;
         ovf_d   = prev_ovf_q;
         armed_d = 1'b0;
      end
`endif
   end

   // Accumulator, flag and strobe registers.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         pulse_q <= pulse_d;
      end
   end

`ifdef ACC_UNDO_EN
   // Undo snapshot, arm flag and undo edge detector.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         prev_acc_q  <= '0;
         prev_ovf_q  <= 1'b0;
         armed_q     <= 1'b0;
         undo_prev_q <= 1'b0;
      end else begin
         prev_acc_q  <= prev_acc_d;
         prev_ovf_q  <= prev_ovf_d;
         armed_q     <= armed_d;
         undo_prev_q <= undo_wire_export;
      end
   end
`endif

   assign led_wire_export  = acc_q;
   assign overflow_export  = ovf_q;
   assign acc_pulse_export = pulse_q;

endmodule
